// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - cluster-wide constants and the arbiter state encoding
package cluster_pkg;

    localparam int NUM_CORES        = 8;
    localparam int GMEM_SIZE        = 4096;
    localparam int DEVICE_ADDR_BITS = 10;

    localparam logic [5:0] DEVICE_PREFIX = 6'b111111;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder, first set bit at or after ptr
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + IW'(i);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gmem_arbiter.sv
// rtl/gmem_arbiter.sv - request-driven round-robin arbiter for the shared global-memory/device port
module gmem_arbiter
    import cluster_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_CORES,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_wren,
    input  logic [NUM_PORTS-1:0]            req_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            mem_wren,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_q,
    output logic                            dev_write_en,
    output logic                            dev_read_en,
    output logic [DEVICE_ADDR_BITS-1:0]     dev_addr,
    output logic [DATA_WIDTH-1:0]           dev_data_out,
    input  logic [DATA_WIDTH-1:0]           dev_data_in,
    output logic [$clog2(NUM_PORTS)-1:0]    dev_core_id
);

    localparam int         IW         = $clog2(NUM_PORTS);
    localparam logic       LOCK_OK    = (MAX_BURST > 1);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);
    localparam logic [IW-1:0] ONE     = IW'(1);

    logic [0:0]           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        lock_port;
    logic [3:0]           beat_cnt;
    logic                 rsp_pend;
    logic [IW-1:0]        rsp_port;
    logic                 rsp_sel_dev;
    logic [IW-1:0]        last_id;

    logic [NUM_PORTS-1:0] pick_req;
    logic [IW-1:0]        grant_idx;
    logic                 grant_any;
    logic [ADDR_WIDTH-1:0] mux_addr;
    logic                 mux_wren;
    logic                 is_dev;

    // While locked, the rest of the cluster is masked out even if lock_port is idle.
    always_comb begin
        pick_req = req_valid;
        if (state == ARB_LOCKED) begin
            pick_req            = '0;
            pick_req[lock_port] = req_valid[lock_port];
        end
    end

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign mux_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign mux_wren = req_wren[grant_idx];
    assign is_dev   = (mux_addr[ADDR_WIDTH-1 -: 6] == DEVICE_PREFIX);

    assign mem_addr     = mux_addr;
    assign mem_wdata    = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign mem_wren     = grant_any & mux_wren & ~is_dev;
    assign dev_write_en = grant_any & mux_wren & is_dev;
    assign dev_read_en  = grant_any & ~mux_wren & is_dev;
    assign dev_addr     = mux_addr[DEVICE_ADDR_BITS-1:0];
    assign dev_data_out = mem_wdata;
    assign dev_core_id  = grant_any ? grant_idx : last_id;

    always_comb begin
        rsp_valid = '0;
        if (rsp_pend) begin
            rsp_valid[rsp_port] = 1'b1;
        end
    end

    assign rsp_data = !rsp_pend ? '0 : (rsp_sel_dev ? dev_data_in : mem_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            lock_port   <= '0;
            beat_cnt    <= '0;
            rsp_pend    <= 1'b0;
            rsp_port    <= '0;
            rsp_sel_dev <= 1'b0;
            last_id     <= '0;
        end else begin
            rsp_pend <= grant_any & ~mux_wren;
            if (grant_any) begin
                last_id <= grant_idx;
                if (!mux_wren) begin
                    rsp_port    <= grant_idx;
                    rsp_sel_dev <= is_dev;
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (grant_any) begin
                        if (req_lock[grant_idx] && LOCK_OK) begin
                            state     <= ARB_LOCKED;
                            lock_port <= grant_idx;
                            beat_cnt  <= 4'd1;
                        end else begin
                            ptr <= grant_idx + ONE;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // The beat that reaches MAX_BURST still completes, then the lock is forced off.
                    if (grant_any && req_lock[lock_port] && (beat_cnt + 4'd1 != BURST_LAST)) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end else begin
                        state    <= ARB_IDLE;
                        ptr      <= lock_port + ONE;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmem_arbiter.sv
// tb/tb_gmem_arbiter.sv - scoreboard bench for gmem_arbiter grants, decode and read responses
module tb_gmem_arbiter;

    localparam int NP = 8;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam logic [15:0] DEV_RD = 16'h1234;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   req_valid = '0;
    logic [NP-1:0]   req_wren = '0;
    logic [NP-1:0]   req_lock = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [NP-1:0]   req_ready;
    logic [NP-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   mem_addr;
    logic            mem_wren;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_q = '0;
    logic            dev_write_en;
    logic            dev_read_en;
    logic [9:0]      dev_addr;
    logic [DW-1:0]   dev_data_out;
    logic [DW-1:0]   dev_data_in = DEV_RD;
    logic [2:0]      dev_core_id;

    int tests_run = 0;
    int tests_failed = 0;
    int last_id = 0;
    int exp_port[$];
    logic [15:0] exp_data[$];

    gmem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_wren    (req_wren),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .mem_q       (mem_q),
        .dev_write_en(dev_write_en),
        .dev_read_en (dev_read_en),
        .dev_addr    (dev_addr),
        .dev_data_out(dev_data_out),
        .dev_data_in (dev_data_in),
        .dev_core_id (dev_core_id)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, content is a fixed function of the address.
    always @(posedge clk) mem_q <= mem_addr ^ 16'h5A5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic w, input logic l,
                            input logic [15:0] a, input logic [15:0] d);
        req_valid[p] = v;
        req_wren[p]  = w;
        req_lock[p]  = l;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_wren  = '0;
        req_lock  = '0;
    endtask

    // Inputs are applied before calling; checks grant, queues expected read data, advances one cycle.
    task automatic tick(input int exp_g, input string tag);
        logic [15:0] a;
        #1;
        if (exp_g < 0) begin
            check({tag, "_ready"}, req_ready, 0);
            check({tag, "_id_hold"}, dev_core_id, last_id);
        end else begin
            check({tag, "_ready"}, req_ready, 32'd1 << exp_g);
            check({tag, "_id"}, dev_core_id, exp_g);
            last_id = exp_g;
            if (!req_wren[exp_g]) begin
                a = req_addr[exp_g*AW +: AW];
                exp_port.push_back(exp_g);
                exp_data.push_back((a[15:10] == 6'h3F) ? DEV_RD : (a ^ 16'h5A5A));
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_all();
        @(negedge clk);
        #2;
        reset = 1'b0;
        last_id = 0;
    endtask

    // Every expected response must appear exactly one cycle after its grant.
    initial begin
        int p;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            if (exp_port.size() != 0) begin
                p = exp_port.pop_front();
                d = exp_data.pop_front();
                check("rsp_valid", rsp_valid, 32'd1 << p);
                check("rsp_data", rsp_data, d);
            end else if (rsp_valid != 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end
        end
    end

    initial begin
        do_reset();
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_core_id", dev_core_id, 0);
        check("rst_state", dut.state, 0);

        // All ports reading: strict rotation 0..7 then 0
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i), 16'h0);
        for (int i = 0; i <= NP; i++) tick(i % NP, "all_rr");
        clr_all();
        tick(-1, "all_idle");

        // Only ports 2 and 5
        do_reset();
        set_port(2, 1'b1, 1'b0, 1'b0, 16'h0222, 16'h0);
        set_port(5, 1'b1, 1'b0, 1'b0, 16'h0555, 16'h0);
        for (int i = 0; i < 4; i++) tick((i % 2) ? 5 : 2, "pair");
        clr_all();

        // Device window write, read, and a plain SRAM write
        set_port(3, 1'b1, 1'b1, 1'b0, 16'hFC12, 16'hBEEF);
        #1;
        check("dw_dev_we", dev_write_en, 1);
        check("dw_mem_we", mem_wren, 0);
        check("dw_addr", dev_addr, 10'h012);
        check("dw_data", dev_data_out, 16'hBEEF);
        tick(3, "dev_wr");
        set_port(3, 1'b1, 1'b0, 1'b0, 16'hFC12, 16'h0);
        #1;
        check("dr_dev_re", dev_read_en, 1);
        check("dr_dev_we", dev_write_en, 0);
        tick(3, "dev_rd");
        set_port(3, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hCAFE);
        #1;
        check("mw_mem_we", mem_wren, 1);
        check("mw_dev_we", dev_write_en, 0);
        check("mw_wdata", mem_wdata, 16'hCAFE);
        tick(3, "mem_wr");
        clr_all();
        #1;
        check("idle_mem_we", mem_wren, 0);
        check("idle_dev_en", {dev_write_en, dev_read_en}, 0);
        tick(-1, "idle");

        // Locked burst capped at MAX_BURST
        do_reset();
        set_port(1, 1'b1, 1'b0, 1'b1, 16'h0201, 16'h0);
        set_port(4, 1'b1, 1'b0, 1'b0, 16'h0204, 16'h0);
        for (int i = 0; i < 4; i++) tick(1, "burst");
        check("burst_ptr", dut.ptr, 2);
        check("burst_state", dut.state, 0);
        tick(4, "burst_other");
        tick(1, "burst_relock");
        set_port(1, 1'b1, 1'b0, 1'b0, 16'h0201, 16'h0);
        tick(1, "burst_unlock");
        req_valid[1] = 1'b0;
        tick(4, "burst_after");
        clr_all();
        tick(-1, "burst_idle");

        // Lock released by dropping req_valid
        do_reset();
        set_port(6, 1'b1, 1'b0, 1'b1, 16'h0306, 16'h0);
        tick(6, "rel_lock");
        check("rel_locked", dut.state, 1);
        req_valid[6] = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0);
        tick(-1, "rel_gap");
        tick(0, "rel_next");
        clr_all();
        tick(-1, "rel_idle");

        // Reset during the response cycle of a locked read drops the response
        do_reset();
        set_port(2, 1'b1, 1'b0, 1'b1, 16'h0402, 16'h0);
        tick(2, "mid_lock");
        #1;
        check("mid_ready", req_ready, 32'd1 << 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rsp_drop", rsp_valid, 0);
        check("mid_state", dut.state, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        last_id = 0;
        clr_all();
        set_port(0, 1'b1, 1'b0, 1'b0, 16'h0500, 16'h0);
        tick(0, "post_rst");
        clr_all();
        tick(-1, "post_idle");

        check("sb_drained", exp_port.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
